// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding bridge from a simple core request/response port onto AXI-lite style AR/R/AW/W/B channels.
// state | meaning: IDLE accept | RD_ADDR ar | RD_DATA r | WR_REQ aw+w | WR_RESP b | RSP core response
module axi_lite_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] arAddr,
    output logic [31:0]       arWidth,
    output logic              arValid,
    input  logic              arReady,
    input  logic [31:0]       rData,
    input  logic              rValid,
    output logic              rReady,
    output logic [ADDR_W-1:0] awAddr,
    output logic [1:0]        awPort,
    output logic              awValid,
    input  logic              awReady,
    output logic [31:0]       wData,
    output logic [3:0]        wStrb,
    output logic              wValid,
    input  logic              wReady,
    input  logic [1:0]        bResp,
    input  logic              bValid,
    output logic              bReady
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

    state_t      state;
    logic        aw_done;
    logic        w_done;
    logic        aw_hs;
    logic        w_hs;
    logic [31:0] size_width;
    logic [3:0]  size_strb;

    always_comb begin
        size_width = 32'd32;
        size_strb  = 4'b1111;
        case (req_size)
            2'd0: begin
                size_width = 32'd8;
                size_strb  = 4'b0001;
            end
            2'd1: begin
                size_width = 32'd16;
                size_strb  = 4'b0011;
            end
            default: ;
        endcase
    end

    assign aw_hs  = awValid && awReady;
    assign w_hs   = wValid && wReady;
    assign awPort = 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            arAddr    <= '0;
            arWidth   <= '0;
            arValid   <= 1'b0;
            rReady    <= 1'b0;
            awAddr    <= '0;
            awValid   <= 1'b0;
            wData     <= '0;
            wStrb     <= '0;
            wValid    <= 1'b0;
            bReady    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_size == 2'd3) begin
                            // illegal size never reaches the bus
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RSP;
                        end else if (req_wen) begin
                            awAddr  <= req_addr;
                            wData   <= 32'(req_wdata);
                            wStrb   <= size_strb;
                            awValid <= 1'b1;
                            wValid  <= 1'b1;
                            state   <= WR_REQ;
                        end else begin
                            arAddr  <= req_addr;
                            arWidth <= size_width;
                            arValid <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (arValid && arReady) begin
                        arValid <= 1'b0;
                        rReady  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rValid && rReady) begin
                        rReady    <= 1'b0;
                        rsp_rdata <= DATA_W'(rData);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awValid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wValid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // advance on the cycle the last of the two handshakes lands
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bReady <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bValid && bReady) begin
                        bReady    <= 1'b0;
                        rsp_err   <= (bResp != 2'b00);
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_master_bridge.md
AXI_LITE_MASTER_BRIDGE -- requirements
Module: axi_lite_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of the request and the AR/AW channels.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is supported.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid/req_ready  input/output  1/1  core-side request handshake.
REQ-006 req_wen  input  1  1=write, 0=read.
REQ-007 req_addr  input  ADDR_W  byte address; req_wdata  input  DATA_W  write data.
REQ-008 req_size  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-009 rsp_valid/rsp_ready  output/input  1/1  core-side response handshake; rsp_rdata  output  DATA_W; rsp_err  output  1.
REQ-010 arAddr  output  32; arWidth  output  32 (bits: 8/16/32); arValid  output  1; arReady  input  1.
REQ-011 rData  input  32; rValid  input  1; rReady  output  1.
REQ-012 awAddr  output  32; awPort  output  2 (constant 2'b00); awValid  output  1; awReady  input  1.
REQ-013 wData  output  32; wStrb  output  4; wValid  output  1; wReady  input  1.
REQ-014 bResp  input  2; bValid  input  1; bReady  output  1.

Function
REQ-015 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP; one transaction outstanding at a time.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid&&req_ready, and address, size, wen, wdata are latched that cycle.
REQ-017 Accepted request with req_size==3 SHALL go directly to RSP with rsp_err=1, rsp_rdata=0, no bus activity.
REQ-018 Legal read -> RD_ADDR: arValid=1 from the next cycle, arAddr=latched address, arWidth=8/16/32 for size 0/1/2.
REQ-019 RD_ADDR -> RD_DATA on arValid&&arReady; arValid deasserts the following cycle.
REQ-020 In RD_DATA rReady=1; on rValid&&rReady, rData is captured into rsp_rdata unmodified, rsp_err=0, state -> RSP.
REQ-021 Legal write -> WR_REQ: awValid=1 and wValid=1 from the next cycle; awAddr=latched address; wData=latched wdata unshifted; wStrb=4'b0001/4'b0011/4'b1111 for size 0/1/2.
REQ-022 In WR_REQ each of awValid/wValid SHALL deassert the cycle after its own handshake, tracked by aw_done/w_done flags; same-cycle handshakes set both flags.
REQ-023 WR_REQ -> WR_RESP when both flags are set (including same cycle as last handshake); flags clear on entry to IDLE.
REQ-024 In WR_RESP bReady=1; on bValid&&bReady, rsp_err=(bResp!=2'b00), rsp_rdata=0, state -> RSP.
REQ-025 In RSP rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_valid&&rsp_ready -> IDLE; a new request can be accepted the cycle after.
REQ-026 Any asserted valid (arValid, awValid, wValid, rsp_valid) SHALL hold with stable payload until its handshake; no valid SHALL depend combinationally on the matching ready.
REQ-027 rReady SHALL be 1 only in RD_DATA; bReady only in WR_RESP; rValid/bValid outside those states are ignored.
REQ-028 Minimum latency: read acceptance to rsp_valid = 3 cycles with zero-wait slave; write likewise 3 cycles.
REQ-029 awPort SHALL be constant 2'b00.

Reset
REQ-030 On reset: state IDLE; req_ready=0 in the reset cycle, 1 the cycle after; arValid, awValid, wValid, rReady, bReady, rsp_valid, rsp_err = 0; rsp_rdata, arAddr, awAddr, wData, wStrb, arWidth = 0.
REQ-031 Reset mid-transaction SHALL abandon it; all valids low on the cycle after reset is sampled; no response is issued for the abandoned request.

Verification
REQ-032 Read word addr 0x80000004, slave arReady=1, rValid next cycle with rData=0xDEADBEEF -> arWidth=32, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-033 Write byte addr 0xA00003F8 data 0x41, awReady delayed 3 cycles, wReady immediate -> wStrb=0001, wValid drops after 1 handshake, awValid held 3 cycles, bReady only after both, rsp_err=0.
REQ-034 Write word with bResp=2'b10 -> rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-035 req_size=3 -> rsp_err=1 next cycle, no arValid/awValid/wValid ever asserted.
REQ-036 Assert reset while in RD_DATA with rValid withheld -> rReady, rsp_valid low next cycle; subsequent read completes normally.
REQ-037 Back-to-back requests with rsp_ready held 0 for 4 cycles -> rsp_rdata stable, req_ready=0 until response consumed.
